// File: rtl/hvac_actuator_driver.sv
`default_nettype none
// ============================================================================
// Module  : hvac_actuator_driver
// Purpose : Drives heater, compressor and fan from heat/cool request levels
//           with fan pre/post-run, minimum on-time and compressor lockout.
// Revision: 1.0 - initial release
// ============================================================================
module hvac_actuator_driver #(
   parameter int FAN_PRE_CYC  = 4,
   parameter int MIN_ON_CYC   = 16,
   parameter int MIN_OFF_CYC  = 32,
   parameter int FAN_POST_CYC = 8,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       heat_req,
   input  logic       cool_req,
   output logic       heater_en,
   output logic       compressor_en,
   output logic       fan_en,
   output logic       cool_blocked,
   output logic       conflict,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FAN_PRE  = 3'd1,
      S_HEAT     = 3'd2,
      S_COOL     = 3'd3,
      S_FAN_POST = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] c_FAN_PRE_LD  = CNT_W'(FAN_PRE_CYC - 1);
   localparam logic [CNT_W-1:0] c_MIN_ON_LD   = CNT_W'(MIN_ON_CYC - 1);
   localparam logic [CNT_W-1:0] c_MIN_OFF_LD  = CNT_W'(MIN_OFF_CYC - 1);
   localparam logic [CNT_W-1:0] c_FAN_POST_LD = CNT_W'(FAN_POST_CYC - 1);
   localparam logic [CNT_W-1:0] c_ONE         = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic             r_tgt_cool;
   logic [CNT_W-1:0] r_phase_tmr;
   logic [CNT_W-1:0] r_lock_tmr;

   state_t           w_state_nxt;
   logic             w_tgt_cool_nxt;
   logic             w_arm_lock;
   logic [CNT_W-1:0] w_phase_ld;
   logic             w_h;
   logic             w_c;
   logic             w_phase_zero;
   logic             w_lock_zero;

   assign w_h          = heat_req & ~cool_req;
   assign w_c          = cool_req & ~heat_req;
   assign w_phase_zero = (r_phase_tmr == '0);
   assign w_lock_zero  = (r_lock_tmr == '0);

   always_comb begin
      w_state_nxt    = r_state;
      w_tgt_cool_nxt = r_tgt_cool;
      w_arm_lock     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_h) begin
               w_state_nxt    = S_FAN_PRE;
               w_tgt_cool_nxt = 1'b0;
            end else if (w_c && w_lock_zero) begin
               w_state_nxt    = S_FAN_PRE;
               w_tgt_cool_nxt = 1'b1;
            end
         end
         S_FAN_PRE: begin
            if (r_tgt_cool ? !w_c : !w_h)
               w_state_nxt = S_FAN_POST;
            else if (w_phase_zero && (!r_tgt_cool || w_lock_zero))
               w_state_nxt = r_tgt_cool ? S_COOL : S_HEAT;
         end
         S_HEAT: begin
            if (w_phase_zero && !w_h)
               w_state_nxt = S_FAN_POST;
         end
         S_COOL: begin
            // Compressor stops on this edge, so the lockout restarts here.
            if (w_phase_zero && !w_c) begin
               w_state_nxt = S_FAN_POST;
               w_arm_lock  = 1'b1;
            end
         end
         S_FAN_POST: begin
            if (w_h)
               w_state_nxt = S_HEAT;
            else if (w_c && w_lock_zero)
               w_state_nxt = S_COOL;
            else if (w_phase_zero)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_phase_ld = '0;
      case (w_state_nxt)
         S_FAN_PRE:       w_phase_ld = c_FAN_PRE_LD;
         S_HEAT, S_COOL:  w_phase_ld = c_MIN_ON_LD;
         S_FAN_POST:      w_phase_ld = c_FAN_POST_LD;
         default:         w_phase_ld = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_tgt_cool  <= 1'b0;
         r_phase_tmr <= '0;
         r_lock_tmr  <= c_MIN_OFF_LD;
      end else begin
         r_state    <= w_state_nxt;
         r_tgt_cool <= w_tgt_cool_nxt;
         if (w_state_nxt != r_state)
            r_phase_tmr <= w_phase_ld;
         else if (!w_phase_zero)
            r_phase_tmr <= r_phase_tmr - c_ONE;
         if (w_arm_lock)
            r_lock_tmr <= c_MIN_OFF_LD;
         else if (!w_lock_zero)
            r_lock_tmr <= r_lock_tmr - c_ONE;
      end
   end

   assign fan_en        = (r_state != S_IDLE);
   assign heater_en     = (r_state == S_HEAT);
   assign compressor_en = (r_state == S_COOL);
   assign conflict      = heat_req & cool_req;
   assign cool_blocked  = w_c & ~w_lock_zero &
                          ((r_state == S_IDLE) | (r_state == S_FAN_PRE) | (r_state == S_FAN_POST));
   assign state_dbg     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hvac_actuator_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_hvac_actuator_driver
// Purpose : Directed plus randomized stimulus against an elapsed-time model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hvac_actuator_driver;

   localparam int FAN_PRE_CYC  = 4;
   localparam int MIN_ON_CYC   = 16;
   localparam int MIN_OFF_CYC  = 32;
   localparam int FAN_POST_CYC = 8;
   localparam int CNT_W        = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       heat_req = 1'b0;
   logic       cool_req = 1'b0;
   logic       heater_en;
   logic       compressor_en;
   logic       fan_en;
   logic       cool_blocked;
   logic       conflict;
   logic [2:0] state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   // Model: state plus cycles spent in it and cycles since the compressor stopped.
   int m_state    = 0;
   bit m_tgt_cool = 1'b0;
   int m_age      = 0;
   int m_since    = 0;

   always #5 clk = ~clk;

   hvac_actuator_driver #(
      .FAN_PRE_CYC (FAN_PRE_CYC),
      .MIN_ON_CYC  (MIN_ON_CYC),
      .MIN_OFF_CYC (MIN_OFF_CYC),
      .FAN_POST_CYC(FAN_POST_CYC),
      .CNT_W       (CNT_W)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .heat_req     (heat_req),
      .cool_req     (cool_req),
      .heater_en    (heater_en),
      .compressor_en(compressor_en),
      .fan_en       (fan_en),
      .cool_blocked (cool_blocked),
      .conflict     (conflict),
      .state_dbg    (state_dbg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   function automatic bit lock_done();
      return m_since >= MIN_OFF_CYC - 1;
   endfunction

   task automatic model_edge(input bit r, input bit h_in, input bit c_in);
      bit h, c, arm;
      int nxt;
      if (r) begin
         m_state = 0; m_tgt_cool = 1'b0; m_age = 0; m_since = 0;
         return;
      end
      h   = h_in & !c_in;
      c   = c_in & !h_in;
      arm = 1'b0;
      nxt = m_state;
      case (m_state)
         0: if (h) begin nxt = 1; m_tgt_cool = 1'b0; end
            else if (c && lock_done()) begin nxt = 1; m_tgt_cool = 1'b1; end
         1: if (!(m_tgt_cool ? c : h)) nxt = 4;
            else if (m_age >= FAN_PRE_CYC && (!m_tgt_cool || lock_done()))
               nxt = m_tgt_cool ? 3 : 2;
         2: if (m_age >= MIN_ON_CYC && !h) nxt = 4;
         3: if (m_age >= MIN_ON_CYC && !c) begin nxt = 4; arm = 1'b1; end
         4: if (h) nxt = 2;
            else if (c && lock_done()) nxt = 3;
            else if (m_age >= FAN_POST_CYC) nxt = 0;
         default: nxt = 0;
      endcase
      m_age   = (nxt == m_state) ? ((m_age < 1000) ? m_age + 1 : m_age) : 1;
      m_since = arm ? 0 : ((m_since < 1000) ? m_since + 1 : m_since);
      m_state = nxt;
   endtask

   task automatic check_outputs(input bit h_in, input bit c_in);
      bit c, blk;
      c   = c_in & !h_in;
      blk = c && !lock_done() && (m_state == 0 || m_state == 1 || m_state == 4);
      chk("state_dbg",     32'(state_dbg),     32'(m_state));
      chk("fan_en",        32'(fan_en),        32'(m_state != 0));
      chk("heater_en",     32'(heater_en),     32'(m_state == 2));
      chk("compressor_en", 32'(compressor_en), 32'(m_state == 3));
      chk("conflict",      32'(conflict),      32'(h_in & c_in));
      chk("cool_blocked",  32'(cool_blocked),  32'(blk));
      chk("heat_cool_excl", 32'(heater_en & compressor_en), 32'd0);
   endtask

   task automatic step(input bit r, input bit h_in, input bit c_in);
      rst      = r;
      heat_req = h_in;
      cool_req = c_in;
      @(posedge clk);
      model_edge(r, h_in, c_in);
      #1;
      check_outputs(h_in, c_in);
   endtask

   task automatic hold(input int n, input bit r, input bit h_in, input bit c_in);
      for (int i = 0; i < n; i++) step(r, h_in, c_in);
   endtask

   initial begin
      // Heat run with release at edge 30.
      hold(2, 1, 0, 0);
      hold(30, 0, 1, 0);
      hold(12, 0, 0, 0);
      // Cool request straight after reset meets the power-on lockout.
      hold(2, 1, 0, 0);
      hold(40, 0, 0, 1);
      hold(30, 0, 0, 0);
      // Single-cycle heat pulse, then a short pulse once HEAT is reached.
      hold(1, 0, 1, 0);
      hold(12, 0, 0, 0);
      hold(6, 0, 1, 0);
      hold(30, 0, 0, 0);
      // Cool run, heat 3 cycles into FAN_POST, then cool again under lockout.
      hold(40, 0, 0, 0);
      hold(30, 0, 0, 1);
      hold(3, 0, 0, 0);
      hold(10, 0, 1, 0);
      hold(20, 0, 0, 0);
      hold(20, 0, 0, 1);
      hold(3, 0, 0, 0);
      hold(45, 0, 0, 1);
      hold(30, 0, 0, 0);
      // Conflicting requests in IDLE.
      hold(5, 0, 1, 1);
      // Heat to cool changeover.
      hold(20, 0, 1, 0);
      hold(70, 0, 0, 1);
      hold(40, 0, 0, 0);
      // Reset mid-COOL, then cool again.
      hold(45, 0, 0, 1);
      hold(1, 1, 0, 1);
      hold(40, 0, 0, 1);
      hold(30, 0, 0, 0);
      // Randomized request segments with occasional resets.
      for (int s = 0; s < 250; s++) begin
         int  len;
         bit  r, h, c;
         len = int'($urandom_range(1, 30));
         r   = ($urandom_range(0, 39) == 0);
         h   = $urandom_range(0, 2) == 0;
         c   = $urandom_range(0, 2) == 0;
         if (r) hold(int'($urandom_range(1, 2)), 1, h, c);
         else   hold(len, 0, h, c);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
